// File: rtl/ysyx_22050598_exu_muldiv.sv
// Iterative RV64M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, one bit per cycle, with the pipeline held via md_stall_o.
module ysyx_22050598_exu_muldiv #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            md_start_i,
    input  logic [2:0]      md_funct3_i,
    input  logic            md_word_i,
    input  logic [XLEN-1:0] alu_op_a,
    input  logic [XLEN-1:0] alu_op_b,
    input  logic            md_flush_i,
    output logic            md_stall_o,
    output logic            md_valid_o,
    output logic [XLEN-1:0] md_result_o
);
    localparam int HALF = XLEN / 2;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, n_reg;
    logic [2:0]          f3_reg;
    logic                word_reg, neg_q_reg, neg_r_reg;
    logic [2*XLEN-1:0]   acc_reg, mcand_reg;
    logic [XLEN-1:0]     mplier_reg, rem_reg, quo_reg, divisor_reg, result_reg;

    logic                accept, busy, last_step;
    logic                a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]     a_sext, b_sext, a_ext, b_ext, mag_a, mag_b;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_result;
    logic [2*XLEN-1:0]   acc_step, prod_fin;
    logic [XLEN:0]       r_shift;
    logic                ge;
    logic [XLEN-1:0]     rem_step, quo_step, q_fin, r_fin, div_val;
    logic [XLEN-1:0]     mul_result, div_result, result_next;

    assign accept     = (state_reg == S_IDLE || state_reg == S_DONE) && md_start_i && !md_flush_i;
    assign busy       = (state_reg == S_MUL || state_reg == S_DIV);
    assign last_step  = (cnt_reg == n_reg - CNT_W'(1));
    assign md_stall_o = accept | (busy & ~md_flush_i);
    assign md_valid_o = (state_reg == S_DONE);
    assign md_result_o = result_reg;

    // Operand preparation for the instruction presented this cycle.
    always_comb begin
        a_signed = md_funct3_i[2] ? ~md_funct3_i[0] : (md_funct3_i != 3'd3);
        b_signed = md_funct3_i[2] ? ~md_funct3_i[0] : ~md_funct3_i[1];
        a_sext   = {{HALF{alu_op_a[HALF-1]}}, alu_op_a[HALF-1:0]};
        b_sext   = {{HALF{alu_op_b[HALF-1]}}, alu_op_b[HALF-1:0]};
        a_ext    = md_word_i ? (a_signed ? a_sext : {{HALF{1'b0}}, alu_op_a[HALF-1:0]}) : alu_op_a;
        b_ext    = md_word_i ? (b_signed ? b_sext : {{HALF{1'b0}}, alu_op_b[HALF-1:0]}) : alu_op_b;
        sign_a   = a_signed & a_ext[XLEN-1];
        sign_b   = b_signed & b_ext[XLEN-1];
        mag_a    = sign_a ? -a_ext : a_ext;
        mag_b    = sign_b ? -b_ext : b_ext;
        div_zero = md_funct3_i[2] && (b_ext == '0);
        div_ovf  = md_funct3_i[2] && !md_funct3_i[0] && (b_ext == '1) &&
                   (a_ext == (md_word_i ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                                        : {1'b1, {(XLEN-1){1'b0}}}));
        special  = div_zero | div_ovf;
        // REMUW by zero still returns the sign-extended 32-bit dividend.
        if (div_zero)
            special_result = md_funct3_i[1] ? (md_word_i ? a_sext : alu_op_a) : '1;
        else
            special_result = md_funct3_i[1] ? '0 : a_ext;
    end

    // One iteration step of each datapath, plus the sign fix-up applied on the last step.
    always_comb begin
        acc_step = mplier_reg[0] ? acc_reg + mcand_reg : acc_reg;
        prod_fin = neg_q_reg ? -acc_step : acc_step;
        if (f3_reg[1:0] == 2'd0)
            mul_result = word_reg ? {{HALF{prod_fin[HALF-1]}}, prod_fin[HALF-1:0]} : prod_fin[XLEN-1:0];
        else
            mul_result = prod_fin[2*XLEN-1:XLEN];

        r_shift  = {rem_reg, quo_reg[XLEN-1]};
        ge       = (r_shift >= {1'b0, divisor_reg});
        rem_step = ge ? XLEN'(r_shift - {1'b0, divisor_reg}) : r_shift[XLEN-1:0];
        quo_step = {quo_reg[XLEN-2:0], ge};
        q_fin    = neg_q_reg ? -quo_step : quo_step;
        r_fin    = neg_r_reg ? -rem_step : rem_step;
        div_val  = f3_reg[1] ? r_fin : q_fin;
        div_result = word_reg ? {{HALF{div_val[HALF-1]}}, div_val[HALF-1:0]} : div_val;

        result_next = accept ? special_result : (f3_reg[2] ? div_result : mul_result);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (accept)
                    state_next = special ? S_DONE : (md_funct3_i[2] ? S_DIV : S_MUL);
                else
                    state_next = S_IDLE;
            end
            S_MUL, S_DIV: if (last_step) state_next = S_DONE;
            default:      state_next = S_IDLE;
        endcase
        if (md_flush_i) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            n_reg       <= '0;
            f3_reg      <= '0;
            word_reg    <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            result_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next == S_DONE) result_reg <= result_next;
            if (accept) begin
                cnt_reg     <= '0;
                n_reg       <= md_word_i ? CNT_W'(HALF) : CNT_W'(XLEN);
                f3_reg      <= md_funct3_i;
                word_reg    <= md_word_i;
                neg_q_reg   <= sign_a ^ sign_b;
                neg_r_reg   <= sign_a;
                acc_reg     <= '0;
                mcand_reg   <= {{XLEN{1'b0}}, mag_a};
                mplier_reg  <= mag_b;
                rem_reg     <= '0;
                // W dividends are left-aligned so the top bit enters first.
                quo_reg     <= md_word_i ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;
                divisor_reg <= mag_b;
            end else if (busy) begin
                cnt_reg    <= cnt_reg + CNT_W'(1);
                acc_reg    <= acc_step;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                rem_reg    <= rem_step;
                quo_reg    <= quo_step;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22050598_exu_muldiv.sv
// Randomized and directed bench for the iterative multiply/divide unit against an
// arithmetic reference of the RV64M result and latency rules.
module tb_ysyx_22050598_exu_muldiv;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        md_start_i;
    logic [2:0]  md_funct3_i;
    logic        md_word_i;
    logic [63:0] alu_op_a, alu_op_b;
    logic        md_flush_i;
    logic        md_stall_o, md_valid_o;
    logic [63:0] md_result_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ysyx_22050598_exu_muldiv dut (
        .clk(clk), .rst_n(rst_n), .md_start_i(md_start_i), .md_funct3_i(md_funct3_i),
        .md_word_i(md_word_i), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .md_flush_i(md_flush_i), .md_stall_o(md_stall_o), .md_valid_o(md_valid_o),
        .md_result_o(md_result_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] sx(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa, sb, sq;
        logic signed [31:0] sa32, sb32, sq32;
        logic [31:0]        a32, b32;
        sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
        case (f3)
            3'd0: begin p = {64'b0, a} * {64'b0, b}; return w ? sx(p[31:0]) : p[63:0]; end
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
            3'd4: begin
                if (w) begin
                    if (b32 == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
                    if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return sx(a32);
                    sq32 = sa32 / sb32; return sx(sq32);
                end
                if (b == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
                if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return a;
                sq = sa / sb; return sq;
            end
            3'd5: begin
                if (w) return (b32 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : sx(a32 / b32);
                return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            end
            3'd6: begin
                if (w) begin
                    if (b32 == 0) return sx(a32);
                    if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 64'd0;
                    sq32 = sa32 % sb32; return sx(sq32);
                end
                if (b == 0) return a;
                if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 64'd0;
                sq = sa % sb; return sq;
            end
            default: begin
                if (w) return (b32 == 0) ? sx(a32) : sx(a32 % b32);
                return (b == 0) ? a : a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        logic bz, ovf;
        if (f3 < 3'd4) return w ? 33 : 65;
        bz  = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf = (f3 == 3'd4 || f3 == 3'd6) &&
              (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                 : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        if (bz || ovf) return 1;
        return w ? 33 : 65;
    endfunction

    // Entered in an IDLE or DONE cycle (after its negedge); returns in the DONE cycle so a
    // following call issues its start back-to-back.
    task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input string tag);
        logic [63:0] exp_res;
        int          exp_lat, lat;
        logic        stall_ok;
        exp_res = ref_result(f3, w, a, b);
        exp_lat = ref_latency(f3, w, a, b);
        md_start_i = 1'b1; md_funct3_i = f3; md_word_i = w; alu_op_a = a; alu_op_b = b;
        #1 check({tag, "_stall_accept"}, 64'(md_stall_o), 64'd1);
        @(posedge clk);
        lat = 0; stall_ok = 1'b1;
        while (lat < 100) begin
            @(negedge clk);
            md_start_i = 1'b0;
            lat++;
            if (md_valid_o) break;
            if (!md_stall_o) stall_ok = 1'b0;
        end
        #1;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, md_result_o, exp_res);
        check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
        check({tag, "_stall_done"}, 64'(md_stall_o), 64'd0);
        $display("op %-10s f3=%0d w=%0d a=%h b=%h res=%h exp=%h lat=%0d",
                 tag, f3, w, a, b, md_result_o, exp_res, lat);
    endtask

    initial begin
        logic [2:0]  f3;
        logic        w, seen;
        logic [63:0] a, b;
        int          sel;

        rst_n = 1'b0; md_start_i = 1'b0; md_funct3_i = '0; md_word_i = 1'b0;
        alu_op_a = '0; alu_op_b = '0; md_flush_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid", 64'(md_valid_o), 64'd0);
        check("reset_stall", 64'(md_stall_o), 64'd0);
        check("reset_result", md_result_o, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd4, 1'b0, -64'sd20, 64'd3, "div_m20_3");
        run_op(3'd6, 1'b0, -64'sd20, 64'd3, "rem_m20_3");
        @(negedge clk);
        run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "mulhu");
        run_op(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "mul");
        run_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "mulhsu");
        @(negedge clk);
        run_op(3'd5, 1'b0, 64'd7, 64'd0, "divu_by0");
        run_op(3'd6, 1'b0, 64'd7, 64'd0, "rem_by0");
        run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "div_ovf");
        run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "rem_ovf");
        run_op(3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "divw_ovf");
        run_op(3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, "mulw");
        @(negedge clk);

        // Flush together with start: the start is rejected.
        md_start_i = 1'b1; md_flush_i = 1'b1; md_funct3_i = 3'd0; md_word_i = 1'b0;
        alu_op_a = 64'd5; alu_op_b = 64'd6;
        #1 check("flush_start_stall", 64'(md_stall_o), 64'd0);
        @(negedge clk);
        md_start_i = 1'b0; md_flush_i = 1'b0;
        #1 check("flush_start_idle", 64'(md_stall_o | md_valid_o), 64'd0);

        // Flush ten cycles into a DIV.
        @(negedge clk);
        md_start_i = 1'b1; md_funct3_i = 3'd4; alu_op_a = 64'd100; alu_op_b = 64'd7;
        @(posedge clk);
        @(negedge clk);
        md_start_i = 1'b0;
        repeat (9) @(negedge clk);
        md_flush_i = 1'b1;
        #1 check("flush_stall", 64'(md_stall_o), 64'd0);
        check("flush_valid", 64'(md_valid_o), 64'd0);
        @(negedge clk);
        md_flush_i = 1'b0;
        #1 check("flush_idle_stall", 64'(md_stall_o), 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (md_valid_o) seen = 1'b1;
        end
        check("flush_no_pulse", 64'(seen), 64'd0);
        run_op(3'd0, 1'b0, 64'd123456789, 64'd987654321, "mul_after_flush");
        @(negedge clk);

        // Asynchronous reset in the middle of a MUL.
        md_start_i = 1'b1; md_funct3_i = 3'd1; alu_op_a = 64'd77; alu_op_b = 64'd99;
        @(posedge clk);
        @(negedge clk);
        md_start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1 check("rst_mid_stall", 64'(md_stall_o), 64'd0);
        check("rst_mid_valid", 64'(md_valid_o), 64'd0);
        check("rst_mid_result", md_result_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            f3  = 3'($urandom_range(0, 7));
            w   = (f3 >= 3'd1 && f3 <= 3'd3) ? 1'b0 : 1'($urandom_range(0, 1));
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = w ? {b[63:32], 32'd0} : 64'd0;
                1: begin
                    a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                2: b = $urandom_range(0, 1) ? 64'($urandom_range(1, 15)) : -64'($urandom_range(1, 15));
                3: a = -64'($urandom_range(0, 100));
                default: ;
            endcase
            run_op(f3, w, a, b, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
